// File: rtl/teeod_ipc_pkg.sv
`default_nettype none
// ============================================================================
// teeod_ipc_pkg : shared response encodings and constants for the IPC responder
// Revision: 1.0
// ============================================================================
package teeod_ipc_pkg;

  typedef logic [1:0] axil_resp_t;

  localparam axil_resp_t RESP_OKAY   = 2'b00;
  localparam axil_resp_t RESP_SLVERR = 2'b10;

  localparam int unsigned DOORBELL_IDX = 0;

endpackage
`default_nettype wire

// File: rtl/teeod_ipc_chan_hold.sv
`default_nettype none
// ============================================================================
// teeod_ipc_chan_hold : one-entry valid/ready hold register for an AXI channel
// Revision: 1.0
// ============================================================================
module teeod_ipc_chan_hold #(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] in_data_i,
  output logic             out_valid_o,
  output logic [WIDTH-1:0] out_data_o,
  input  logic             pop_i
);

  logic             valid_q, valid_d;
  logic             ready_q, ready_d;
  logic [WIDTH-1:0] data_q, data_d;

  // Ready is registered so it stays low while reset is asserted.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (in_valid_i && ready_q) begin
      valid_d = 1'b1;
      data_d  = in_data_i;
    end else if (pop_i) begin
      valid_d = 1'b0;
    end
    ready_d = !valid_d;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      ready_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      ready_q <= ready_d;
      data_q  <= data_d;
    end
  end

  assign in_ready_o  = ready_q;
  assign out_valid_o = valid_q;
  assign out_data_o  = data_q;

endmodule
`default_nettype wire

// File: rtl/teeod_ipc_axil_responder.sv
`default_nettype none
// ============================================================================
// teeod_ipc_axil_responder : AXI4-Lite mailbox register slave with doorbell irq
// Revision: 1.0
// ============================================================================
module teeod_ipc_axil_responder
  import teeod_ipc_pkg::*;
#(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4,
  parameter int NUM_REGS           = 4
) (
  input  logic                            S_AXI_ACLK,
  input  logic                            S_AXI_ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [2:0]                      S_AXI_AWPROT,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [2:0]                      S_AXI_ARPROT,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
  output logic [NUM_REGS*C_S_AXI_DATA_WIDTH-1:0] reg_o,
  output logic [NUM_REGS-1:0]             reg_wr_o,
  output logic                            doorbell_irq_o,
  input  logic                            irq_ack_i
);

  localparam int DW    = C_S_AXI_DATA_WIDTH;
  localparam int SW    = DW / 8;
  localparam int IDX_W = C_S_AXI_ADDR_WIDTH - 2;

  logic             aw_full, w_full, commit;
  logic [IDX_W-1:0] aw_idx, ar_idx;
  logic [DW-1:0]    w_data;
  logic [SW-1:0]    w_strb;
  logic             wr_ok, rd_ok, ar_hs;

  logic [DW-1:0]       regs_q [NUM_REGS];
  logic [DW-1:0]       regs_d [NUM_REGS];
  logic [NUM_REGS-1:0] reg_wr_q, reg_wr_d;
  logic                irq_q, irq_d;
  logic                bvalid_q, bvalid_d;
  axil_resp_t          bresp_q, bresp_d;
  logic                rvalid_q, rvalid_d;
  axil_resp_t          rresp_q, rresp_d;
  logic [DW-1:0]       rdata_q, rdata_d;
  logic                ar_en_q;

  logic unused_ok;
  assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

  teeod_ipc_chan_hold #(.WIDTH(IDX_W)) u_aw_hold (
    .clk_i       (S_AXI_ACLK),
    .rst_ni      (S_AXI_ARESETN),
    .in_valid_i  (S_AXI_AWVALID),
    .in_ready_o  (S_AXI_AWREADY),
    .in_data_i   (S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2]),
    .out_valid_o (aw_full),
    .out_data_o  (aw_idx),
    .pop_i       (commit)
  );

  teeod_ipc_chan_hold #(.WIDTH(DW + SW)) u_w_hold (
    .clk_i       (S_AXI_ACLK),
    .rst_ni      (S_AXI_ARESETN),
    .in_valid_i  (S_AXI_WVALID),
    .in_ready_o  (S_AXI_WREADY),
    .in_data_i   ({S_AXI_WSTRB, S_AXI_WDATA}),
    .out_valid_o (w_full),
    .out_data_o  ({w_strb, w_data}),
    .pop_i       (commit)
  );

  // A pending B response that is not being taken blocks the next commit.
  assign commit = aw_full && w_full && (!bvalid_q || S_AXI_BREADY);
  assign wr_ok  = {{(32-IDX_W){1'b0}}, aw_idx} < 32'(NUM_REGS);
  assign ar_idx = S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:2];
  assign rd_ok  = {{(32-IDX_W){1'b0}}, ar_idx} < 32'(NUM_REGS);
  assign S_AXI_ARREADY = ar_en_q && (!rvalid_q || S_AXI_RREADY);
  assign ar_hs  = S_AXI_ARVALID && S_AXI_ARREADY;

  always_comb begin
    regs_d   = regs_q;
    reg_wr_d = '0;
    irq_d    = irq_q && !irq_ack_i;
    bvalid_d = bvalid_q;
    bresp_d  = bresp_q;
    if (commit) begin
      bvalid_d = 1'b1;
      bresp_d  = wr_ok ? RESP_OKAY : RESP_SLVERR;
      for (int i = 0; i < NUM_REGS; i++) begin
        if (wr_ok && aw_idx == IDX_W'(i)) begin
          for (int k = 0; k < SW; k++) begin
            if (w_strb[k]) regs_d[i][8*k +: 8] = w_data[8*k +: 8];
          end
          reg_wr_d[i] = |w_strb;
        end
      end
      // Setting wins over a simultaneous acknowledge.
      if (wr_ok && aw_idx == IDX_W'(DOORBELL_IDX) && |w_strb) irq_d = 1'b1;
    end else if (S_AXI_BREADY) begin
      bvalid_d = 1'b0;
    end
  end

  always_comb begin
    rvalid_d = rvalid_q;
    rresp_d  = rresp_q;
    rdata_d  = rdata_q;
    if (ar_hs) begin
      rvalid_d = 1'b1;
      rresp_d  = rd_ok ? RESP_OKAY : RESP_SLVERR;
      rdata_d  = '0;
      for (int i = 0; i < NUM_REGS; i++) begin
        if (ar_idx == IDX_W'(i)) rdata_d = regs_q[i];
      end
    end else if (S_AXI_RREADY) begin
      rvalid_d = 1'b0;
    end
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
      reg_wr_q <= '0;
      irq_q    <= 1'b0;
      bvalid_q <= 1'b0;
      bresp_q  <= RESP_OKAY;
      rvalid_q <= 1'b0;
      rresp_q  <= RESP_OKAY;
      rdata_q  <= '0;
      ar_en_q  <= 1'b0;
    end else begin
      regs_q   <= regs_d;
      reg_wr_q <= reg_wr_d;
      irq_q    <= irq_d;
      bvalid_q <= bvalid_d;
      bresp_q  <= bresp_d;
      rvalid_q <= rvalid_d;
      rresp_q  <= rresp_d;
      rdata_q  <= rdata_d;
      ar_en_q  <= 1'b1;
    end
  end

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg_out
    assign reg_o[DW*i +: DW] = regs_q[i];
  end

  assign reg_wr_o       = reg_wr_q;
  assign doorbell_irq_o = irq_q;
  assign S_AXI_BVALID   = bvalid_q;
  assign S_AXI_BRESP    = bresp_q;
  assign S_AXI_RVALID   = rvalid_q;
  assign S_AXI_RRESP    = rresp_q;
  assign S_AXI_RDATA    = rdata_q;

endmodule
`default_nettype wire

// File: tb/tb_teeod_ipc_axil_responder.sv
`default_nettype none
// ============================================================================
// tb_teeod_ipc_axil_responder : directed bench for a 4-register and a 3-register
// responder sharing one stimulus bus. Revision: 1.0
// ============================================================================
module tb_teeod_ipc_axil_responder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  awaddr = '0, araddr = '0;
  logic        awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0, arvalid = 1'b0, rready = 1'b0;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic        irq_ack = 1'b0;

  logic         a_awready, a_wready, a_bvalid, a_arready, a_rvalid, a_irq;
  logic [1:0]   a_bresp, a_rresp;
  logic [31:0]  a_rdata;
  logic [127:0] a_reg;
  logic [3:0]   a_wr;
  logic         b_awready, b_wready, b_bvalid, b_arready, b_rvalid, b_irq;
  logic [1:0]   b_bresp, b_rresp;
  logic [31:0]  b_rdata;
  logic [95:0]  b_reg;
  logic [2:0]   b_wr;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  teeod_ipc_axil_responder #(.C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(4), .NUM_REGS(4)) dut (
    .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(3'b000), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(a_awready),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(a_wready),
    .S_AXI_BRESP(a_bresp), .S_AXI_BVALID(a_bvalid), .S_AXI_BREADY(bready),
    .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(3'b000), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(a_arready),
    .S_AXI_RDATA(a_rdata), .S_AXI_RRESP(a_rresp), .S_AXI_RVALID(a_rvalid), .S_AXI_RREADY(rready),
    .reg_o(a_reg), .reg_wr_o(a_wr), .doorbell_irq_o(a_irq), .irq_ack_i(irq_ack)
  );

  teeod_ipc_axil_responder #(.C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(4), .NUM_REGS(3)) dut3 (
    .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(3'b000), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(b_awready),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(b_wready),
    .S_AXI_BRESP(b_bresp), .S_AXI_BVALID(b_bvalid), .S_AXI_BREADY(bready),
    .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(3'b000), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(b_arready),
    .S_AXI_RDATA(b_rdata), .S_AXI_RRESP(b_rresp), .S_AXI_RVALID(b_rvalid), .S_AXI_RREADY(rready),
    .reg_o(b_reg), .reg_wr_o(b_wr), .doorbell_irq_o(b_irq), .irq_ack_i(irq_ack)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Full write with BREADY high; returns what both instances showed on the BVALID cycle.
  task automatic bus_write(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           output logic [1:0] resp_a, output logic [1:0] resp_b,
                           output logic [3:0] pulse_a, output logic [2:0] pulse_b,
                           output logic irq_a, output bit ok);
    bit aw_hs, w_hs;
    ok = 0; resp_a = 'x; resp_b = 'x; pulse_a = 'x; pulse_b = 'x; irq_a = 'x;
    awaddr = addr; wdata = data; wstrb = strb;
    awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
    for (int i = 0; i < 20 && !ok; i++) begin
      aw_hs = awvalid && a_awready;
      w_hs  = wvalid && a_wready;
      step();
      if (aw_hs) awvalid = 1'b0;
      if (w_hs) wvalid = 1'b0;
      if (a_bvalid) begin
        ok = 1; resp_a = a_bresp; resp_b = b_bresp;
        pulse_a = a_wr; pulse_b = b_wr; irq_a = a_irq;
      end
    end
    awvalid = 1'b0; wvalid = 1'b0;
    step();
  endtask

  task automatic bus_read(input logic [3:0] addr,
                          output logic [31:0] data_a, output logic [1:0] resp_a,
                          output logic [31:0] data_b, output logic [1:0] resp_b, output bit ok);
    bit hs;
    ok = 0; data_a = 'x; resp_a = 'x; data_b = 'x; resp_b = 'x;
    araddr = addr; arvalid = 1'b1; rready = 1'b1;
    for (int i = 0; i < 20 && !ok; i++) begin
      hs = arvalid && a_arready;
      step();
      if (hs) arvalid = 1'b0;
      if (a_rvalid) begin
        ok = 1; data_a = a_rdata; resp_a = a_rresp; data_b = b_rdata; resp_b = b_rresp;
      end
    end
    arvalid = 1'b0;
    step();
  endtask

  task automatic test_reset();
    repeat (2) step();
    checks++;
    if ({a_awready, a_wready, a_arready, a_bvalid, a_rvalid} !== 5'b0) begin
      errors++; $display("FAIL reset_handshake: got %b required 00000", {a_awready, a_wready, a_arready, a_bvalid, a_rvalid});
    end
    rst_n = 1'b1;
    repeat (2) step();
    checks++;
    if ({a_reg, a_wr, a_irq, a_bresp, a_rresp, a_rdata} !== '0) begin
      errors++; $display("FAIL reset_state: reg=%h wr=%b irq=%b required all zero", a_reg, a_wr, a_irq);
    end
    checks++;
    if ({a_awready, a_wready, a_arready} !== 3'b111) begin
      errors++; $display("FAIL reset_ready_release: got %b required 111", {a_awready, a_wready, a_arready});
    end
  endtask

  task automatic test_basic_rw();
    logic [1:0] ra, rb; logic [3:0] pa; logic [2:0] pb; logic irq; bit ok;
    logic [31:0] da, db;
    for (int i = 0; i < 4; i++) begin
      bus_write(4'(i * 4), 32'(i + 1), 4'hF, ra, rb, pa, pb, irq, ok);
      checks++;
      if (!ok || ra !== 2'b00 || pa !== 4'(1 << i)) begin
        errors++; $display("FAIL basic_write[%0d]: ok=%0d resp=%b pulse=%b required resp=00 pulse=%b", i, ok, ra, pa, 4'(1 << i));
      end
    end
    for (int i = 0; i < 4; i++) begin
      bus_read(4'(i * 4), da, ra, db, rb, ok);
      checks++;
      if (!ok || da !== 32'(i + 1) || ra !== 2'b00) begin
        errors++; $display("FAIL basic_read[%0d]: ok=%0d data=%h resp=%b required %h/00", i, ok, da, ra, 32'(i + 1));
      end
    end
    checks++;
    if (a_reg !== {32'd4, 32'd3, 32'd2, 32'd1}) begin
      errors++; $display("FAIL basic_reg_o: got %h required 00000004000000030000000200000001", a_reg);
    end
  endtask

  task automatic test_w_before_aw();
    wdata = 32'h1234_5678; wstrb = 4'hF; wvalid = 1'b1; bready = 1'b1;
    step();
    wvalid = 1'b0;
    checks++;
    if (a_wready !== 1'b0) begin
      errors++; $display("FAIL wfirst_wready: got %b required 0", a_wready);
    end
    repeat (2) step();
    checks++;
    if (a_bvalid !== 1'b0) begin
      errors++; $display("FAIL wfirst_early_b: got %b required 0", a_bvalid);
    end
    awaddr = 4'h8; awvalid = 1'b1;
    step();
    awvalid = 1'b0;
    checks++;
    if (a_bvalid !== 1'b0) begin
      errors++; $display("FAIL wfirst_b_latency: got %b required 0", a_bvalid);
    end
    step();
    checks++;
    if (a_bvalid !== 1'b1 || a_bresp !== 2'b00 || a_wr !== 4'b0100 || a_reg[95:64] !== 32'h1234_5678) begin
      errors++; $display("FAIL wfirst_commit: bvalid=%b resp=%b wr=%b reg2=%h required 1/00/0100/12345678", a_bvalid, a_bresp, a_wr, a_reg[95:64]);
    end
    step();
  endtask

  task automatic test_strobes();
    logic [1:0] ra, rb; logic [3:0] pa; logic [2:0] pb; logic irq; bit ok;
    logic [31:0] da, db;
    bus_write(4'h4, 32'h0000_0002, 4'hF, ra, rb, pa, pb, irq, ok);
    bus_write(4'h4, 32'hAABB_CCDD, 4'b0101, ra, rb, pa, pb, irq, ok);
    checks++;
    if (!ok || ra !== 2'b00 || pa !== 4'b0010) begin
      errors++; $display("FAIL strb_write: ok=%0d resp=%b pulse=%b required 00/0010", ok, ra, pa);
    end
    bus_read(4'h4, da, ra, db, rb, ok);
    checks++;
    if (!ok || da !== 32'h00BB_00DD) begin
      errors++; $display("FAIL strb_read: got %h required 00bb00dd", da);
    end
    bus_write(4'h4, 32'hFFFF_FFFF, 4'b0000, ra, rb, pa, pb, irq, ok);
    checks++;
    if (!ok || ra !== 2'b00 || pa !== 4'b0000) begin
      errors++; $display("FAIL strb_zero_write: ok=%0d resp=%b pulse=%b required 00/0000", ok, ra, pa);
    end
    bus_read(4'h4, da, ra, db, rb, ok);
    checks++;
    if (!ok || da !== 32'h00BB_00DD) begin
      errors++; $display("FAIL strb_zero_read: got %h required 00bb00dd", da);
    end
  endtask

  task automatic test_doorbell();
    logic [1:0] ra, rb; logic [3:0] pa; logic [2:0] pb; logic irq; bit ok;
    irq_ack = 1'b1;
    step();
    irq_ack = 1'b0;
    checks++;
    if (a_irq !== 1'b0) begin
      errors++; $display("FAIL irq_ack_clear: got %b required 0", a_irq);
    end
    bus_write(4'h0, 32'h11, 4'hF, ra, rb, pa, pb, irq, ok);
    checks++;
    if (!ok || irq !== 1'b1) begin
      errors++; $display("FAIL irq_set: got %b required 1", irq);
    end
    // Second reg 0 write with the ack landing exactly on the commit cycle.
    awaddr = 4'h0; wdata = 32'h22; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
    step();
    awvalid = 1'b0; wvalid = 1'b0; irq_ack = 1'b1;
    step();
    irq_ack = 1'b0;
    checks++;
    if (a_bvalid !== 1'b1 || a_irq !== 1'b1) begin
      errors++; $display("FAIL irq_set_and_ack: bvalid=%b irq=%b required 1/1", a_bvalid, a_irq);
    end
    step();
    irq_ack = 1'b1;
    step();
    irq_ack = 1'b0;
    checks++;
    if (a_irq !== 1'b0) begin
      errors++; $display("FAIL irq_ack_alone: got %b required 0", a_irq);
    end
  endtask

  task automatic test_out_of_range();
    logic [1:0] ra, rb; logic [3:0] pa; logic [2:0] pb; logic irq; bit ok;
    logic [31:0] da, db;
    bus_write(4'hC, 32'hDEAD_BEEF, 4'hF, ra, rb, pa, pb, irq, ok);
    checks++;
    if (!ok || rb !== 2'b10 || pb !== 3'b000) begin
      errors++; $display("FAIL oor_write: ok=%0d resp=%b pulse=%b required 10/000", ok, rb, pb);
    end
    checks++;
    if (ra !== 2'b00 || pa !== 4'b1000) begin
      errors++; $display("FAIL inrange_write: resp=%b pulse=%b required 00/1000", ra, pa);
    end
    checks++;
    if (b_reg !== {32'h1234_5678, 32'h00BB_00DD, 32'h0000_0022}) begin
      errors++; $display("FAIL oor_reg_o: got %h required 1234567800bb00dd00000022", b_reg);
    end
    bus_read(4'hC, da, ra, db, rb, ok);
    checks++;
    if (!ok || db !== 32'h0 || rb !== 2'b10) begin
      errors++; $display("FAIL oor_read: data=%h resp=%b required 00000000/10", db, rb);
    end
    checks++;
    if (da !== 32'hDEAD_BEEF || ra !== 2'b00) begin
      errors++; $display("FAIL inrange_read: data=%h resp=%b required deadbeef/00", da, ra);
    end
  endtask

  task automatic test_backpressure_reset();
    bready = 1'b0; rready = 1'b0;
    awaddr = 4'h0; wdata = 32'h55; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    araddr = 4'h4; arvalid = 1'b1;
    step();
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    step();
    checks++;
    if (a_bvalid !== 1'b1 || a_reg[31:0] !== 32'h55 || a_irq !== 1'b1) begin
      errors++; $display("FAIL bp_first_commit: bvalid=%b reg0=%h irq=%b required 1/00000055/1", a_bvalid, a_reg[31:0], a_irq);
    end
    awaddr = 4'h8; wdata = 32'h99; awvalid = 1'b1; wvalid = 1'b1;
    step();
    awvalid = 1'b0; wvalid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      checks++;
      if ({a_bvalid, a_bresp, a_rvalid, a_rresp, a_rdata, a_awready, a_wready, a_arready, a_reg[95:64]} !==
          {1'b1, 2'b00, 1'b1, 2'b00, 32'h00BB_00DD, 1'b0, 1'b0, 1'b0, 32'h1234_5678}) begin
        errors++; $display("FAIL bp_hold[%0d]: b=%b/%b r=%b/%b/%h rdy=%b%b%b reg2=%h", i, a_bvalid, a_bresp,
                           a_rvalid, a_rresp, a_rdata, a_awready, a_wready, a_arready, a_reg[95:64]);
      end
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({a_bvalid, a_rvalid, b_bvalid, b_rvalid, a_irq} !== 5'b0 || a_reg !== '0 || b_reg !== '0) begin
      errors++; $display("FAIL bp_reset: valids=%b irq=%b reg=%h required all zero", {a_bvalid, a_rvalid, b_bvalid, b_rvalid}, a_irq, a_reg);
    end
    bready = 1'b1; rready = 1'b1;
    step();
    rst_n = 1'b1;
    repeat (3) step();
    checks++;
    if (a_reg !== '0 || a_wr !== 4'b0 || a_bvalid !== 1'b0 || {a_awready, a_wready} !== 2'b11) begin
      errors++; $display("FAIL bp_after_reset: reg=%h wr=%b bvalid=%b rdy=%b%b required zero/0000/0/11", a_reg, a_wr, a_bvalid, a_awready, a_wready);
    end
  endtask

  initial begin
    test_reset();
    test_basic_rw();
    test_w_before_aw();
    test_strobes();
    test_doorbell();
    test_out_of_range();
    test_backpressure_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
